game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Parametrised game-flow sequencer for the rhythm game.
- Successor to the top-level GAMESTART/EASY/NORMAL/FAILURE FSM; generalised to NUM_LEVELS difficulty levels.
- Adds a pre-play countdown, pause/resume, a CLEAR result state, auto-return timeout and optional level unlocking.
- Drives the script, judge, player and composite blocks through registered state, level and play-enable outputs.

Parameters:
- NUM_LEVELS, 4, number of selectable levels (1..NUM_LEVELS); level 0 means none.
- LVL_W, 3, width of level fields; must satisfy 2^LVL_W > NUM_LEVELS.
- COUNT_TICKS, 3, countdown length in tick pulses before PLAY; 0 skips the countdown.
- RESULT_TICKS, 5, ticks spent in CLEAR/FAILURE before auto-return to IDLE; 0 means wait for return_req only.
- UNLOCK, 1, 1 means level L>1 is startable only after level L-1 is cleared; 0 means all levels are open.
- CNT_W, 4, width of the countdown/result counter; must hold max(COUNT_TICKS, RESULT_TICKS).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle timebase pulse (e.g. one per second) from the clock divider.
- start_req  in  1  one-cycle pulse requesting a game start.
- start_level  in  LVL_W  level requested with start_req.
- gameend  in  1  script finished, level-sensitive.
- fail  in  1  player life exhausted, level-sensitive.
- pause_req  in  1  one-cycle pulse toggling pause.
- return_req  in  1  one-cycle pulse returning to the menu.
- state_o  out  3  current state code.
- level_o  out  LVL_W  latched active level; 0 in IDLE.
- play_en  out  1  high only in PLAY; gates script advance and judging.
- countdown_o  out  CNT_W  remaining countdown ticks in COUNTDOWN, else 0.
- state_chg  out  1  one-cycle pulse on the cycle after any state transition.
- cleared_mask  out  NUM_LEVELS  sticky bit per level cleared; bit i = level i+1.

Behaviour:
- All outputs are registered and update on the clock edge after the causing input.
- Reset values: state_o=IDLE(0), level_o=0, play_en=0, countdown_o=0, state_chg=0, cleared_mask=0, internal counter=0.
- Reset mid-operation aborts immediately to IDLE. cleared_mask is cleared only by rst.
- State codes: IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, CLEAR=4, FAILURE=5. Codes 6–7 are illegal and recover to IDLE on the next edge.
- IDLE:
  - start_req is accepted only if 1 <= start_level <= NUM_LEVELS, and, when UNLOCK=1, start_level==1 or cleared_mask[start_level-2]==1.
  - On accept, latch level_o=start_level.
  - If COUNT_TICKS>0: go to COUNTDOWN with counter=COUNT_TICKS. Otherwise go straight to PLAY.
  - Rejected requests cause no change and no state_chg.
- COUNTDOWN:
  - countdown_o mirrors the counter.
  - Each tick decrements the counter; a tick while counter==1 enters PLAY with counter=0.
  - return_req goes to IDLE and takes priority over tick.
  - pause_req, fail and gameend are ignored.
- PLAY:
  - play_en=1.
  - Same-cycle priority: fail > gameend > return_req > pause_req.
  - fail goes to FAILURE; gameend goes to CLEAR; return_req goes to IDLE; pause_req goes to PAUSE.
- PAUSE:
  - play_en=0.
  - pause_req resumes PLAY; return_req goes to IDLE (priority over pause_req).
  - fail and gameend are ignored.
  - The counter is not touched.
- Entering CLEAR sets cleared_mask[level_o-1] in the same edge.
- CLEAR and FAILURE:
  - Load counter=RESULT_TICKS on entry.
  - If RESULT_TICKS>0, each tick decrements the counter; a tick while counter==1 returns to IDLE.
  - return_req returns to IDLE at any time.
  - level_o holds its value until IDLE is entered, then goes to 0.
- state_chg: asserted for exactly one cycle when state_o differs from its previous value. It is not asserted by reset.
- Single-cycle events: tick, start_req, pause_req and return_req arriving in a state that ignores them are dropped, not queued.

Test Plan:
- Countdown and clear path (defaults): start_req with start_level=1, then 3 ticks, then assert gameend. Required: COUNTDOWN with countdown_o 3→2→1, PLAY after the 3rd tick, CLEAR one cycle after gameend, cleared_mask=0001, IDLE after 5 ticks, level_o=0.
- Unlock rule: after reset, start_req with start_level=2 leaves state IDLE and state_chg=0. After clearing level 1, the same request is accepted with level_o=2. start_level=0 and start_level=5 are always rejected.
- Simultaneous fail and gameend in PLAY → FAILURE; cleared_mask is unchanged.
- Pause: pause_req in PLAY gives PAUSE with play_en=0. Holding fail=1 in PAUSE keeps PAUSE. A second pause_req gives PLAY, then FAILURE on the next edge while fail is still held.
- Timeout disabled (RESULT_TICKS=0) and countdown skipped (COUNT_TICKS=0): start_req enters PLAY directly; FAILURE stays through 20 ticks until return_req gives IDLE.
- Async reset asserted mid-COUNTDOWN and again mid-PLAY with cleared_mask=0011: all outputs return to their reset values without a clock edge, and cleared_mask becomes 0000.

Source files
------------

// File: rtl/game_flow_if.sv
// Handshake bundle between the game-flow sequencer and the rest of the rhythm game.
// The master drives the request pulses and the slave drives the registered status.
interface game_flow_if #(
  parameter int NUM_LEVELS = 4,
  parameter int LVL_W      = 3,
  parameter int CNT_W      = 4
);
  logic                  tick;
  logic                  start_req;
  logic [LVL_W-1:0]      start_level;
  logic                  gameend;
  logic                  fail;
  logic                  pause_req;
  logic                  return_req;
  logic [2:0]            state_o;
  logic [LVL_W-1:0]      level_o;
  logic                  play_en;
  logic [CNT_W-1:0]      countdown_o;
  logic                  state_chg;
  logic [NUM_LEVELS-1:0] cleared_mask;

  modport master (
    output tick, start_req, start_level, gameend, fail, pause_req, return_req,
    input  state_o, level_o, play_en, countdown_o, state_chg, cleared_mask
  );

  modport slave (
    input  tick, start_req, start_level, gameend, fail, pause_req, return_req,
    output state_o, level_o, play_en, countdown_o, state_chg, cleared_mask
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: IDLE -> COUNTDOWN -> PLAY <-> PAUSE -> CLEAR/FAILURE -> IDLE,
// with per-level unlock tracking and tick-based countdown / result timeout.
module game_flow_ctrl #(
  parameter int NUM_LEVELS   = 4,
  parameter int LVL_W        = 3,
  parameter int COUNT_TICKS  = 3,
  parameter int RESULT_TICKS = 5,
  parameter int UNLOCK       = 1,
  parameter int CNT_W        = 4
) (
  input  logic         clk,
  input  logic         rst,
  game_flow_if.slave   bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COUNTDOWN = 3'd1;
  localparam logic [2:0] S_PLAY      = 3'd2;
  localparam logic [2:0] S_PAUSE     = 3'd3;
  localparam logic [2:0] S_CLEAR     = 3'd4;
  localparam logic [2:0] S_FAILURE   = 3'd5;

  logic [2:0]            state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [LVL_W-1:0]      lvl_q, lvl_n;
  logic [NUM_LEVELS-1:0] mask_q, mask_n;
  logic                  play_en_q;
  logic [CNT_W-1:0]      countdown_q;
  logic                  state_chg_q;

  // A level is startable when in range and, with unlocking, its predecessor is cleared.
  function automatic logic level_ok(input logic [LVL_W-1:0] l,
                                    input logic [NUM_LEVELS-1:0] m);
    logic ok;
    ok = (l != '0) && (l <= LVL_W'(NUM_LEVELS));
    if (UNLOCK != 0) begin
      for (int i = 0; i < NUM_LEVELS - 1; i++) begin
        if (l == LVL_W'(i + 2)) ok = ok && m[i];
      end
    end
    return ok;
  endfunction

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    lvl_n   = lvl_q;
    mask_n  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_req && level_ok(bus.start_level, mask_q)) begin
          lvl_n = bus.start_level;
          if (COUNT_TICKS > 0) begin
            state_n = S_COUNTDOWN;
            cnt_n   = CNT_W'(COUNT_TICKS);
          end else begin
            state_n = S_PLAY;
            cnt_n   = '0;
          end
        end
      end
      S_COUNTDOWN: begin
        if (bus.return_req) begin
          state_n = S_IDLE;
        end else if (bus.tick) begin
          if (cnt_q == CNT_W'(1)) begin
            state_n = S_PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (bus.fail) begin
          state_n = S_FAILURE;
          cnt_n   = CNT_W'(RESULT_TICKS);
        end else if (bus.gameend) begin
          state_n = S_CLEAR;
          cnt_n   = CNT_W'(RESULT_TICKS);
          for (int i = 0; i < NUM_LEVELS; i++) begin
            if (lvl_q == LVL_W'(i + 1)) mask_n[i] = 1'b1;
          end
        end else if (bus.return_req) begin
          state_n = S_IDLE;
        end else if (bus.pause_req) begin
          state_n = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (bus.return_req)     state_n = S_IDLE;
        else if (bus.pause_req) state_n = S_PLAY;
      end
      S_CLEAR, S_FAILURE: begin
        if (bus.return_req) begin
          state_n = S_IDLE;
        end else if ((RESULT_TICKS > 0) && bus.tick) begin
          if (cnt_q == CNT_W'(1)) state_n = S_IDLE;
          else                    cnt_n   = cnt_q - CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Leaving to the menu always drops the active level and the counter.
    if (state_n == S_IDLE) begin
      lvl_n = '0;
      cnt_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lvl_q       <= '0;
      mask_q      <= '0;
      play_en_q   <= 1'b0;
      countdown_q <= '0;
      state_chg_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      lvl_q       <= lvl_n;
      mask_q      <= mask_n;
      play_en_q   <= (state_n == S_PLAY);
      countdown_q <= (state_n == S_COUNTDOWN) ? cnt_n : '0;
      state_chg_q <= (state_n != state_q);
    end
  end

  assign bus.state_o      = state_q;
  assign bus.level_o      = lvl_q;
  assign bus.play_en      = play_en_q;
  assign bus.countdown_o  = countdown_q;
  assign bus.state_chg    = state_chg_q;
  assign bus.cleared_mask = mask_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Vector-table bench for game_flow_ctrl: a default instance and a no-countdown,
// no-timeout, all-levels-open instance share one stimulus stream.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_flow_if #(.NUM_LEVELS(4), .LVL_W(3), .CNT_W(4)) ifa ();
  game_flow_if #(.NUM_LEVELS(4), .LVL_W(3), .CNT_W(4)) ifb ();

  game_flow_ctrl #(.NUM_LEVELS(4), .LVL_W(3), .COUNT_TICKS(3), .RESULT_TICKS(5),
                   .UNLOCK(1), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  game_flow_ctrl #(.NUM_LEVELS(4), .LVL_W(3), .COUNT_TICKS(0), .RESULT_TICKS(0),
                   .UNLOCK(0), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    bit         sel;
    bit         op;
    logic       tk, sr;
    logic [2:0] sl;
    logic       ge, fl, pr, rr;
    logic [2:0] st;
    logic [2:0] lv;
    logic       pe;
    logic [3:0] cd;
    logic       sc;
    logic [3:0] mk;
  } vec_t;

  typedef struct {
    bit         sel;
    int         idx;
    logic [2:0] st;
    logic [2:0] lv;
    logic       pe;
    logic [3:0] cd;
    logic       sc;
    logic [3:0] mk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   applied    = 0;
  int   miscompares = 0;

  function automatic vec_t v(bit sel, logic tk, logic sr, logic [2:0] sl, logic ge,
                             logic fl, logic pr, logic rr, logic [2:0] st,
                             logic [2:0] lv, logic pe, logic [3:0] cd, logic sc,
                             logic [3:0] mk);
    vec_t r;
    r.sel = sel; r.op = 1'b0;
    r.tk = tk; r.sr = sr; r.sl = sl; r.ge = ge; r.fl = fl; r.pr = pr; r.rr = rr;
    r.st = st; r.lv = lv; r.pe = pe; r.cd = cd; r.sc = sc; r.mk = mk;
    return r;
  endfunction

  // Asynchronous reset record: everything zero without a clock edge.
  function automatic vec_t rv(bit sel);
    vec_t r;
    r = v(sel, 0,0,0,0,0,0,0, 0,0,0,0,0,0);
    r.op = 1'b1;
    return r;
  endfunction

  // Default instance: start a level and run the 3-tick countdown into PLAY.
  task automatic push_to_play(logic [2:0] lvl, logic [3:0] mk);
    vecs.push_back(v(0, 0,1,lvl,0,0,0,0, 1,lvl,0,3,1,mk));
    vecs.push_back(v(0, 1,0,0,0,0,0,0,   1,lvl,0,2,0,mk));
    vecs.push_back(v(0, 1,0,0,0,0,0,0,   1,lvl,0,1,0,mk));
    vecs.push_back(v(0, 1,0,0,0,0,0,0,   2,lvl,1,0,1,mk));
  endtask

  task automatic drive(vec_t x);
    ifa.tick = x.tk; ifa.start_req = x.sr; ifa.start_level = x.sl; ifa.gameend = x.ge;
    ifa.fail = x.fl; ifa.pause_req = x.pr; ifa.return_req = x.rr;
    ifb.tick = x.tk; ifb.start_req = x.sr; ifb.start_level = x.sl; ifb.gameend = x.ge;
    ifb.fail = x.fl; ifb.pause_req = x.pr; ifb.return_req = x.rr;
  endtask

  task automatic push_exp(vec_t x, int idx);
    exp_t e;
    e.sel = x.sel; e.idx = idx; e.st = x.st; e.lv = x.lv; e.pe = x.pe;
    e.cd = x.cd; e.sc = x.sc; e.mk = x.mk;
    sb.push_back(e);
  endtask

  task automatic compare_one();
    exp_t e;
    logic [2:0] st, lv;
    logic pe, sc;
    logic [3:0] cd, mk;
    e = sb.pop_front();
    if (e.sel) begin
      st = ifb.state_o; lv = ifb.level_o; pe = ifb.play_en;
      cd = ifb.countdown_o; sc = ifb.state_chg; mk = ifb.cleared_mask;
    end else begin
      st = ifa.state_o; lv = ifa.level_o; pe = ifa.play_en;
      cd = ifa.countdown_o; sc = ifa.state_chg; mk = ifa.cleared_mask;
    end
    applied++;
    if (st !== e.st || lv !== e.lv || pe !== e.pe || cd !== e.cd ||
        sc !== e.sc || mk !== e.mk) begin
      miscompares++;
      $display("FAIL vec%0d dut_%s: got st=%0d lv=%0d pe=%0b cd=%0d sc=%0b mk=%b, want st=%0d lv=%0d pe=%0b cd=%0d sc=%0b mk=%b",
               e.idx, e.sel ? "b" : "a", st, lv, pe, cd, sc, mk,
               e.st, e.lv, e.pe, e.cd, e.sc, e.mk);
    end
  endtask

  task automatic apply(vec_t x, int idx);
    if (x.op) begin
      @(negedge clk);
      #1;
      drive(x);
      rst = 1'b1;
      push_exp(x, idx);
      #1;
      compare_one();
      #1;
      rst = 1'b0;
    end else begin
      @(negedge clk);
      drive(x);
      push_exp(x, idx);
      @(posedge clk);
      #1;
      compare_one();
    end
  endtask

  initial begin
    drive(v(0, 0,0,0,0,0,0,0, 0,0,0,0,0,0));

    // Reset state, then the rejected start requests under the unlock rule.
    vecs.push_back(rv(0));
    vecs.push_back(rv(1));
    vecs.push_back(v(0, 0,1,2,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(0, 0,1,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(0, 0,1,5,0,0,0,0, 0,0,0,0,0,0));
    // Countdown with ignored pause/fail/gameend, then clear and 5-tick timeout.
    vecs.push_back(v(0, 0,1,1,0,0,0,0, 1,1,0,3,1,0));
    vecs.push_back(v(0, 0,0,0,0,0,0,0, 1,1,0,3,0,0));
    vecs.push_back(v(0, 1,0,0,0,0,0,0, 1,1,0,2,0,0));
    vecs.push_back(v(0, 0,0,0,1,1,1,0, 1,1,0,2,0,0));
    vecs.push_back(v(0, 1,0,0,0,0,0,0, 1,1,0,1,0,0));
    vecs.push_back(v(0, 1,0,0,0,0,0,0, 2,1,1,0,1,0));
    vecs.push_back(v(0, 0,0,0,1,0,0,0, 4,1,0,0,1,1));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0, 1,0,0,0,0,0,0, 4,1,0,0,0,1));
    vecs.push_back(v(0, 1,0,0,0,0,0,0, 0,0,0,0,1,1));
    // Level 2 now open; return beats tick in COUNTDOWN; level 3 still locked.
    vecs.push_back(v(0, 0,1,2,0,0,0,0, 1,2,0,3,1,1));
    vecs.push_back(v(0, 1,0,0,0,0,0,1, 0,0,0,0,1,1));
    vecs.push_back(v(0, 0,1,3,0,0,0,0, 0,0,0,0,0,1));
    push_to_play(2, 4'b0001);
    vecs.push_back(v(0, 0,0,0,1,0,0,0, 4,2,0,0,1,3));
    vecs.push_back(v(0, 0,0,0,0,0,0,1, 0,0,0,0,1,3));
    // Fail and gameend together: FAILURE, mask unchanged; return exits early.
    push_to_play(1, 4'b0011);
    vecs.push_back(v(0, 0,0,0,1,1,0,0, 5,1,0,0,1,3));
    vecs.push_back(v(0, 1,0,0,0,0,0,0, 5,1,0,0,0,3));
    vecs.push_back(v(0, 0,0,0,0,0,0,1, 0,0,0,0,1,3));
    // Pause holds against fail/gameend/tick, resume, then the held fail lands.
    push_to_play(1, 4'b0011);
    vecs.push_back(v(0, 0,0,0,0,0,1,0, 3,1,0,0,1,3));
    vecs.push_back(v(0, 0,0,0,0,1,0,0, 3,1,0,0,0,3));
    vecs.push_back(v(0, 0,0,0,1,1,0,0, 3,1,0,0,0,3));
    vecs.push_back(v(0, 1,0,0,0,1,0,0, 3,1,0,0,0,3));
    vecs.push_back(v(0, 0,0,0,0,1,1,0, 2,1,1,0,1,3));
    vecs.push_back(v(0, 0,0,0,0,1,0,0, 5,1,0,0,1,3));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0, 1,0,0,0,0,0,0, 5,1,0,0,0,3));
    vecs.push_back(v(0, 1,0,0,0,0,0,0, 0,0,0,0,1,3));
    // PLAY priorities: return over pause, gameend over return and pause.
    push_to_play(2, 4'b0011);
    vecs.push_back(v(0, 0,0,0,0,0,1,1, 0,0,0,0,1,3));
    push_to_play(2, 4'b0011);
    vecs.push_back(v(0, 0,0,0,1,0,1,1, 4,2,0,0,1,3));
    vecs.push_back(v(0, 0,0,0,0,0,0,1, 0,0,0,0,1,3));
    // Async reset mid-PLAY with mask 0011, then mid-COUNTDOWN.
    push_to_play(1, 4'b0011);
    vecs.push_back(rv(0));
    vecs.push_back(v(0, 0,0,0,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(0, 0,1,2,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(0, 0,1,1,0,0,0,0, 1,1,0,3,1,0));
    vecs.push_back(v(0, 1,0,0,0,0,0,0, 1,1,0,2,0,0));
    vecs.push_back(rv(0));
    vecs.push_back(v(0, 0,0,0,0,0,0,0, 0,0,0,0,0,0));
    // No-countdown, no-timeout, all-open instance.
    vecs.push_back(rv(1));
    vecs.push_back(v(1, 0,1,3,0,0,0,0, 2,3,1,0,1,0));
    vecs.push_back(v(1, 0,0,0,0,0,1,0, 3,3,0,0,1,0));
    vecs.push_back(v(1, 0,0,0,0,0,1,0, 2,3,1,0,1,0));
    vecs.push_back(v(1, 0,0,0,0,1,0,0, 5,3,0,0,1,0));
    for (int i = 0; i < 20; i++) vecs.push_back(v(1, 1,0,0,0,0,0,0, 5,3,0,0,0,0));
    vecs.push_back(v(1, 0,0,0,0,0,0,1, 0,0,0,0,1,0));
    vecs.push_back(v(1, 0,1,5,0,0,0,0, 0,0,0,0,0,0));
    vecs.push_back(v(1, 0,1,4,0,0,0,0, 2,4,1,0,1,0));
    vecs.push_back(v(1, 0,0,0,1,0,0,0, 4,4,0,0,1,8));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1, 1,0,0,0,0,0,0, 4,4,0,0,0,8));
    vecs.push_back(v(1, 0,0,0,0,0,0,1, 0,0,0,0,1,8));

    foreach (vecs[i]) apply(vecs[i], i);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
